// File: rtl/dpram_fifo_ctrl.sv
// dpram_fifo_ctrl: streams a simple-dual-port RAM as a valid/ready FIFO with a 2-entry show-ahead output buffer
module dpram_fifo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [DATA_W-1:0] ram_q
);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(1) << ADDR_W;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] mem_cnt;
  logic [RD_LATENCY-1:0] pipe;
  logic [1:0] occ, inflight;
  logic [DATA_W-1:0] head, tail;
  logic push, pop, issue, cap;
  assign full          = count == DEPTH;
  assign empty         = count == '0;
  assign in_ready      = !reset && !full;
  assign push          = in_valid && in_ready;
  assign out_valid     = occ != 2'd0;
  assign out_data      = head;
  assign pop           = out_valid && out_ready;
  assign cap           = pipe[RD_LATENCY-1];
  // a slot freed by this cycle's pop may be refilled, which keeps one-per-cycle streaming at RD_LATENCY=1
  assign issue         = mem_cnt != '0 && 3'(occ) + 3'(inflight) < 3'(pop) + 3'd2;
  assign ram_wren      = push;
  assign ram_wraddress = wr_ptr;
  assign ram_data      = in_data;
  assign ram_rdaddress = rd_ptr;
  // number of reads issued whose data has not yet been captured
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 2'(pipe[i]);
  end
  // pointers, counters, read pipeline and output buffer; capture lands in the first slot left after a pop
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      count   <= '0;
      pipe    <= '0;
      occ     <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
      count   <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      pipe    <= RD_LATENCY'({pipe, issue});
      occ     <= occ + 2'(cap) - 2'(pop);
      if (pop) head <= tail;
      if (cap && occ - 2'(pop) == 2'd0) head <= ram_q;
      if (cap && occ - 2'(pop) != 2'd0) tail <= ram_q;
    end
  end
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb_dpram_fifo_ctrl: randomized and directed checks of dpram_fifo_ctrl against a queue reference model
module tb_dpram_fifo_ctrl;
  logic clk = 0;
  logic rst;
  logic [7:0] in_data, out_data, ram_data, ram_q;
  logic in_valid, in_ready, out_valid, out_ready, full, empty, ram_wren;
  logic [4:0] count;
  logic [3:0] ram_wraddress, ram_rdaddress;
  logic [7:0] in_data2, out_data2, ram_data2, ram_q2, q2a;
  logic in_valid2, in_ready2, out_valid2, out_ready2, full2, empty2, ram_wren2;
  logic [4:0] count2;
  logic [3:0] ram_wraddress2, ram_rdaddress2;
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [7:0] q [$];
  int wp, n, checks, errors;
  logic prev_stall;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LATENCY(1)) dut (
    .clock(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .full(full), .empty(empty), .ram_data(ram_data), .ram_wraddress(ram_wraddress),
    .ram_wren(ram_wren), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q));

  dpram_fifo_ctrl #(.DATA_W(8), .ADDR_W(4), .RD_LATENCY(2)) dut2 (
    .clock(clk), .reset(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .count(count2),
    .full(full2), .empty(empty2), .ram_data(ram_data2), .ram_wraddress(ram_wraddress2),
    .ram_wren(ram_wren2), .ram_rdaddress(ram_rdaddress2), .ram_q(ram_q2));

  always @(posedge clk) begin
    if (ram_wren) mem1[ram_wraddress] <= ram_data;
    ram_q <= mem1[ram_rdaddress];
  end

  always @(posedge clk) begin
    if (ram_wren2) mem2[ram_wraddress2] <= ram_data2;
    q2a    <= mem2[ram_rdaddress2];
    ram_q2 <= q2a;
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [7:0] d, input logic ordy);
    logic rdy, ps, pp, ov;
    logic [7:0] od;
    rst = r; in_valid = iv; in_data = d; out_ready = ordy;
    #3;
    rdy = !r && q.size() < 16;
    ps  = iv && rdy;
    ov  = out_valid;
    od  = out_data;
    pp  = ov && ordy && !r;
    chk("in_ready", in_ready, rdy);
    chk("ram_wren", ram_wren, ps);
    if (ps) begin
      chk("wraddress", ram_wraddress, wp % 16);
      chk("ram_data", ram_data, d);
    end
    chk("count", count, q.size());
    chk("full", full, q.size() == 16);
    chk("empty", empty, q.size() == 0);
    chk("spurious_ov", ov && q.size() == 0, 1'b0);
    if (prev_stall) begin
      chk("stall_ov", ov, 1'b1);
      chk("stall_data", od, prev_data);
    end
    if (pp && q.size() > 0) chk("out_data", od, q[0]);
    @(posedge clk); #1;
    if (r) begin
      q.delete();
      wp = 0;
    end else begin
      if (pp && q.size() > 0) void'(q.pop_front());
      if (ps) begin
        q.push_back(d);
        wp++;
      end
    end
    prev_stall = ov && !ordy && !r;
    prev_data  = od;
  endtask

  initial begin
    checks = 0; errors = 0; wp = 0; prev_stall = 0; prev_data = 0;
    rst = 1; in_valid = 0; in_data = 0; out_ready = 0;
    in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(1, 1, 8'h11, 1);
    step(0, 0, 8'h00, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 8'(8'hFF - i), 0);
    step(0, 1, 8'h55, 0);
    step(0, 1, 8'h66, 1);
    step(0, 1, 8'h77, 0);
    n = 0;
    while (q.size() > 0 && n < 40) begin
      chk("drain_no_gap", out_valid, 1'b1);
      step(0, 0, 8'h00, 1);
      n++;
    end
    chk("drain_empty", empty, 1'b1);
    step(0, 1, 8'hA5, 0);
    n = 0;
    while (!out_valid && n < 10) begin
      step(0, 0, 8'h00, 0);
      n++;
    end
    chk("latency_rd1", n, 2);
    chk("latency_rd1_data", out_data, 8'hA5);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 1000; i++)
      step(0, $urandom_range(0, 99) < (i < 500 ? 80 : 35), 8'($urandom),
           $urandom_range(0, 99) < (i < 500 ? 40 : 85));
    n = 0;
    while (q.size() > 0 && n < 100) begin
      step(0, 0, 8'h00, 1);
      n++;
    end
    chk("random_drain_empty", empty, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h40 + i), 0);
    step(0, 0, 8'h00, 1);
    step(1, 0, 8'h00, 0);
    chk("midreset_count", count, 0);
    chk("midreset_ov", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0);
    step(0, 1, 8'h3C, 0);
    n = 0;
    while (!out_valid && n < 10) begin
      step(0, 0, 8'h00, 0);
      n++;
    end
    chk("midreset_latency", n, 2);
    chk("midreset_data", out_data, 8'h3C);
    step(0, 0, 8'h00, 1);
    chk("midreset_empty", empty, 1'b1);
    in_valid2 = 1; in_data2 = 8'hA5;
    #3;
    chk("rd2_wren", ram_wren2, 1'b1);
    @(posedge clk); #1;
    in_valid2 = 0;
    n = 0;
    while (!out_valid2 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency_rd2", n, 3);
    chk("latency_rd2_data", out_data2, 8'hA5);
    chk("rd2_count", count2, 1);
    out_ready2 = 1;
    @(posedge clk); #1;
    out_ready2 = 0;
    chk("rd2_empty", empty2, 1'b1);
    chk("rd2_ov", out_valid2, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
